// File: rtl/transistor_sequencer.sv
// Power sequencer for a single transistor cell: ramps supply then gate up, gate then
// supply down, and verifies the cell's p/n feedback at the end of every settle window.
module transistor_sequencer #(
    parameter int unsigned SETTLE = 4,
    parameter int unsigned CW     = 8
) (
    input  logic       pin_clk,
    input  logic       pin_rst_n,
    input  logic       pin_req_on,
    input  logic       pin_req_off,
    input  logic       pin_clr_fault,
    input  logic       pin_p_out,
    input  logic       pin_n_out,
    output logic       pin_vdd,
    output logic       pin_gate,
    output logic       pin_busy,
    output logic       pin_done,
    output logic       pin_fault,
    output logic [2:0] pin_state
);

    localparam logic [2:0] S_OFF     = 3'd0;
    localparam logic [2:0] S_VDD_UP  = 3'd1;
    localparam logic [2:0] S_GATE_UP = 3'd2;
    localparam logic [2:0] S_ON      = 3'd3;
    localparam logic [2:0] S_GATE_DN = 3'd4;
    localparam logic [2:0] S_VDD_DN  = 3'd5;
    localparam logic [2:0] S_FAULT   = 3'd6;

    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          vdd_q, vdd_d;
    logic          gate_q, gate_d;
    logic          done_q, done_d;
    logic          mis_q, mis_d;

    logic          last_cycle;
    logic          fb_ok;

    // The cell's expected response follows directly from what we drive it with.
    assign last_cycle = (cnt_q == '0);
    assign fb_ok      = (pin_p_out == (vdd_q & ~gate_q)) && (pin_n_out == (vdd_q & gate_q));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mis_d   = 1'b0;
        case (state_q)
            S_OFF: begin
                if (pin_req_on && !pin_req_off) begin
                    state_d = S_VDD_UP;
                    cnt_d   = CNT_LOAD;
                end
            end
            S_VDD_UP, S_GATE_UP, S_GATE_DN, S_VDD_DN: begin
                if (!last_cycle) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (!fb_ok) begin
                    state_d = S_FAULT;
                end else begin
                    cnt_d = CNT_LOAD;
                    case (state_q)
                        S_VDD_UP:  state_d = S_GATE_UP;
                        S_GATE_UP: begin state_d = S_ON;      cnt_d = '0; end
                        S_GATE_DN: state_d = S_VDD_DN;
                        default:   begin state_d = S_OFF;     cnt_d = '0; end
                    endcase
                end
            end
            S_ON: begin
                // A single-cycle feedback glitch is tolerated; two in a row is a fault.
                if (!fb_ok && mis_q) begin
                    state_d = S_FAULT;
                end else if (pin_req_off) begin
                    state_d = S_GATE_DN;
                    cnt_d   = CNT_LOAD;
                end else begin
                    mis_d = !fb_ok;
                end
            end
            S_FAULT: begin
                if (pin_clr_fault) begin
                    state_d = S_OFF;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_OFF;
                cnt_d   = '0;
            end
        endcase
    end

    // Drives are decoded from the next state so vdd and gate always move on the same
    // edge as the state; gate can never be high without vdd.
    always_comb begin
        vdd_d  = (state_d == S_VDD_UP) || (state_d == S_GATE_UP) ||
                 (state_d == S_ON)     || (state_d == S_GATE_DN);
        gate_d = (state_d == S_GATE_UP) || (state_d == S_ON);
        done_d = ((state_q == S_GATE_UP) && (state_d == S_ON)) ||
                 ((state_q == S_VDD_DN)  && (state_d == S_OFF));
    end

    always_ff @(posedge pin_clk or negedge pin_rst_n) begin
        if (!pin_rst_n) begin
            state_q <= S_OFF;
            cnt_q   <= '0;
            vdd_q   <= 1'b0;
            gate_q  <= 1'b0;
            done_q  <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vdd_q   <= vdd_d;
            gate_q  <= gate_d;
            done_q  <= done_d;
            mis_q   <= mis_d;
        end
    end

    assign pin_vdd   = vdd_q;
    assign pin_gate  = gate_q;
    assign pin_done  = done_q;
    assign pin_state = state_q;
    assign pin_busy  = (state_q == S_VDD_UP) || (state_q == S_GATE_UP) ||
                       (state_q == S_GATE_DN) || (state_q == S_VDD_DN);
    assign pin_fault = (state_q == S_FAULT);

endmodule
